// File: rtl/dot_product_scheduler_pkg.sv
// Shared state encoding and default widths for the dot-product scheduler slice.
package dot_product_scheduler_pkg;

    // Defaults shared with the vector summer and the matrix-multiply top level.
    localparam int DEF_DW    = 4;   // index width
    localparam int DEF_SW    = 17;  // datapath result width
    localparam int DEF_LAT   = 3;   // issue-to-result latency of the datapath
    localparam int DEF_DEPTH = 4;   // result FIFO entries

    // Scheduler pass states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mm_sync_fifo.sv
// First-word-fall-through synchronous FIFO: the head entry is visible while not empty.
module mm_sync_fifo
    import dot_product_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_SW + 2 * DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot being written, so both proceed.
    assign do_push  = push && (!full || do_pop);
    // Masking the head keeps the outputs at zero while nothing is stored.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage write.
    // NOTE: the storage array has no reset; validity lives entirely in count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dot_product_scheduler.sv
// Sequences one matrix-multiply pass: walks (row,col) row-major, issues operand
// requests under a credit limit, tags results through the fixed-latency datapath
// and drains them in order over a valid/ready port.
module dot_product_scheduler
    import dot_product_scheduler_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int SW    = DEF_SW,
    parameter int LAT   = DEF_LAT,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          start,
    input  logic [DW-1:0] numRows,
    input  logic [DW-1:0] numCols,
    output logic          busy,
    output logic          done,
    output logic          issueValid,
    output logic [DW-1:0] rowIdx,
    output logic [DW-1:0] colIdx,
    input  logic [SW-1:0] dpSum,
    output logic          resValid,
    output logic [SW-1:0] resData,
    output logic [DW-1:0] resRow,
    output logic [DW-1:0] resCol,
    input  logic          resReady
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = SW + 2 * DW;

    state_e                 state_q, state_d;
    logic [DW-1:0]          rows_q, rows_d;
    logic [DW-1:0]          cols_q, cols_d;
    logic [DW-1:0]          row_q, row_d;
    logic [DW-1:0]          col_q, col_d;
    logic [CW-1:0]          credits_q, credits_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [LAT-1:0]         tag_vld_q, tag_vld_d;
    logic [LAT-1:0][DW-1:0] tag_row_q, tag_row_d;
    logic [LAT-1:0][DW-1:0] tag_col_q, tag_col_d;

    logic                   issue, last_col, last_issue, pop, drain_exit;
    logic                   fifo_push, fifo_full, fifo_empty;
    logic [FW-1:0]          fifo_wdata, fifo_rdata;
    logic [CW-1:0]          fifo_count;

    // A credit freed by this cycle's pop can be spent by this cycle's issue,
    // which keeps the request stream gap-free when DEPTH >= LAT+1.
    assign pop        = !fifo_empty && resReady;
    assign issue      = (state_q == ST_ISSUE) && ((credits_q != '0) || pop);
    assign last_col   = (col_q == cols_q - DW'(1));
    assign last_issue = issue && last_col && (row_q == rows_q - DW'(1));
    assign fifo_push  = tag_vld_q[LAT-1];
    assign fifo_wdata = {dpSum, tag_row_q[LAT-1], tag_col_q[LAT-1]};
    // The pass ends once nothing is in flight and the final entry leaves this cycle.
    assign drain_exit = (tag_vld_q == '0) &&
                        (fifo_empty || ((fifo_count == CW'(1)) && pop));

    assign busy       = busy_q;
    assign done       = done_q;
    assign issueValid = issue;
    assign rowIdx     = row_q;
    assign colIdx     = col_q;
    assign resValid   = !fifo_empty;
    assign {resData, resRow, resCol} = fifo_rdata;

    // Next-state logic for the pass FSM, index walk, credits and tag pipe.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        row_d     = row_q;
        col_d     = col_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rows_d = numRows;
                    cols_d = numCols;
                    row_d  = '0;
                    col_d  = '0;
                    state_d = ((numRows != '0) && (numCols != '0)) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + DW'(1);
                    end else begin
                        col_d = col_q + DW'(1);
                    end
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_exit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d    = (state_d == ST_DONE);
        credits_d = credits_q - CW'(issue) + CW'(pop);

        tag_vld_d[0] = issue;
        tag_row_d[0] = row_q;
        tag_col_d[0] = col_q;
        for (int i = 1; i < LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_row_d[i] = tag_row_q[i-1];
            tag_col_d[i] = tag_col_q[i-1];
        end
    end

    // State registers; reset abandons any pass and flushes the tag pipe.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (Reset) begin
            state_q   <= ST_IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            credits_q <= CW'(DEPTH);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tag_vld_q <= '0;
            tag_row_q <= '0;
            tag_col_q <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            row_q     <= row_d;
            col_q     <= col_d;
            credits_q <= credits_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tag_vld_q <= tag_vld_d;
            tag_row_q <= tag_row_d;
            tag_col_q <= tag_col_d;
        end
    end

    mm_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk       (Clock),
        .rst       (Reset),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Credits bound in-flight plus stored results, so a full FIFO never sees a push.
    a_no_overflow: assert property (@(posedge Clock) disable iff (Reset)
        !(fifo_push && fifo_full));

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Directed scoreboard bench for dot_product_scheduler with a LAT-cycle datapath model.
module tb_dot_product_scheduler;
    import dot_product_scheduler_pkg::*;

    localparam int DW    = 4;
    localparam int SW    = 17;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam logic [SW-1:0] JUNK = 17'h15A5A;

    logic          Clock = 1'b0;
    logic          Reset, start, resReady;
    logic [DW-1:0] numRows, numCols;
    logic          busy, done, issueValid, resValid;
    logic [DW-1:0] rowIdx, colIdx, resRow, resCol;
    logic [SW-1:0] dpSum, resData;

    dot_product_scheduler #(.DW(DW), .SW(SW), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .start      (start),
        .numRows    (numRows),
        .numCols    (numCols),
        .busy       (busy),
        .done       (done),
        .issueValid (issueValid),
        .rowIdx     (rowIdx),
        .colIdx     (colIdx),
        .dpSum      (dpSum),
        .resValid   (resValid),
        .resData    (resData),
        .resRow     (resRow),
        .resCol     (resCol),
        .resReady   (resReady)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] c;
        logic [SW-1:0] d;
    } exp_t;

    exp_t exp_iss_q[$];
    exp_t exp_res_q[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    int issue_cnt, pop_cnt, resv_cnt, done_cnt = 0;
    int first_iss_cyc, last_iss_cyc, last_pop_cyc, done_cyc, start_cyc;
    int d0;

    always @(posedge Clock) cyc++;

    // Datapath model: returns row*16+col exactly LAT cycles after the request.
    logic [LAT-1:0]         dp_vld = '0;
    logic [LAT-1:0][SW-1:0] dp_pipe = '0;
    always @(posedge Clock) begin
        dp_vld  <= {dp_vld[LAT-2:0], issueValid};
        dp_pipe <= {dp_pipe[LAT-2:0], SW'(rowIdx) * SW'(16) + SW'(colIdx)};
    end
    assign dpSum = dp_vld[LAT-1] ? dp_pipe[LAT-1] : JUNK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Monitor: compares issued requests and accepted results against the scoreboard.
    always @(negedge Clock) begin : monitor
        exp_t e;
        if (!Reset) begin
            if (issueValid) begin
                if (issue_cnt == 0) first_iss_cyc = cyc;
                last_iss_cyc = cyc;
                issue_cnt++;
                if (exp_iss_q.size() == 0) begin
                    check("issue_unplanned", 32'(issueValid), 32'd0);
                end else begin
                    e = exp_iss_q.pop_front();
                    check("issue_row", 32'(rowIdx), 32'(e.r));
                    check("issue_col", 32'(colIdx), 32'(e.c));
                end
            end
            if (resValid) resv_cnt++;
            if (resValid && resReady) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                if (exp_res_q.size() == 0) begin
                    check("res_unplanned", 32'(resValid), 32'd0);
                end else begin
                    e = exp_res_q.pop_front();
                    check("res_data", 32'(resData), 32'(e.d));
                    check("res_row",  32'(resRow),  32'(e.r));
                    check("res_col",  32'(resCol),  32'(e.c));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_counts();
        issue_cnt = 0;
        pop_cnt   = 0;
        resv_cnt  = 0;
    endtask

    task automatic plan_pass(input int rows, input int cols);
        exp_t e;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                e.r = DW'(r);
                e.c = DW'(c);
                e.d = SW'(r * 16 + c);
                exp_iss_q.push_back(e);
                exp_res_q.push_back(e);
            end
        end
    endtask

    task automatic start_pass(input int rows, input int cols);
        numRows   = DW'(rows);
        numCols   = DW'(cols);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        check({tag, "_seen"}, 32'(done), 32'd1);
        tick();
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_issueValid"}, 32'(issueValid), 32'd0);
        check({tag, "_rowIdx"},     32'(rowIdx),     32'd0);
        check({tag, "_colIdx"},     32'(colIdx),     32'd0);
        check({tag, "_resValid"},   32'(resValid),   32'd0);
        check({tag, "_resData"},    32'(resData),    32'd0);
        check({tag, "_resRow"},     32'(resRow),     32'd0);
        check({tag, "_resCol"},     32'(resCol),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b1;
        start    = 1'b0;
        numRows  = '0;
        numCols  = '0;
        resReady = 1'b1;
        clear_counts();
        repeat (3) tick();
        Reset = 1'b0;
        check_all_zero("reset");
        tick();

        // 1: 2x3, consumer always ready.
        clear_counts();
        plan_pass(2, 3);
        start_pass(2, 3);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done");
        check("t1_issues", 32'(issue_cnt), 32'd6);
        check("t1_issue_span", 32'(last_iss_cyc - first_iss_cyc), 32'd5);
        check("t1_pops", 32'(pop_cnt), 32'd6);
        check("t1_done_lag", 32'(done_cyc - last_pop_cyc), 32'd1);
        check("t1_sb_left", 32'(exp_res_q.size()), 32'd0);

        // 2: zero rows finishes without issuing.
        clear_counts();
        start_pass(0, 5);
        wait_done("t2_done");
        check("t2_issues", 32'(issue_cnt), 32'd0);
        check("t2_resvalid", 32'(resv_cnt), 32'd0);
        check("t2_done_cycle", 32'(done_cyc - start_cyc), 32'd1);

        // 3: 2x2 with consumer stalled fills the FIFO; head is held.
        clear_counts();
        resReady = 1'b0;
        plan_pass(2, 2);
        start_pass(2, 2);
        repeat (8) tick();
        check("t3_issues", 32'(issue_cnt), 32'd4);
        check("t3_issue_idle", 32'(issueValid), 32'd0);
        check("t3_resvalid", 32'(resValid), 32'd1);
        check("t3_head_data", 32'(resData), 32'd0);
        tick();
        check("t3_hold_valid", 32'(resValid), 32'd1);
        check("t3_hold_data", 32'(resData), 32'd0);
        check("t3_hold_tag", 32'({resRow, resCol}), 32'd0);
        resReady = 1'b1;
        wait_done("t3_done");
        check("t3_pops", 32'(pop_cnt), 32'd4);
        check("t3_sb_left", 32'(exp_res_q.size()), 32'd0);

        // 4: 3x3 with consumer toggling every cycle.
        clear_counts();
        plan_pass(3, 3);
        d0 = done_cnt;
        start_pass(3, 3);
        for (int i = 0; i < 300 && done_cnt == d0; i++) begin
            resReady = (i % 2 == 0);
            tick();
        end
        resReady = 1'b1;
        check("t4_done_once", 32'(done_cnt - d0), 32'd1);
        check("t4_issues", 32'(issue_cnt), 32'd9);
        check("t4_pops", 32'(pop_cnt), 32'd9);
        check("t4_sb_left", 32'(exp_res_q.size()), 32'd0);
        tick();

        // 4b: credits are back at DEPTH: a stalled 3x3 issues exactly DEPTH and holds (1,1).
        clear_counts();
        resReady = 1'b0;
        plan_pass(3, 3);
        start_pass(3, 3);
        repeat (10) tick();
        check("t4b_issues", 32'(issue_cnt), 32'(DEPTH));
        check("t4b_stalled", 32'(issueValid), 32'd0);
        check("t4b_hold_idx", 32'({rowIdx, colIdx}), 32'({4'd1, 4'd1}));
        resReady = 1'b1;
        wait_done("t4b_done");
        check("t4b_pops", 32'(pop_cnt), 32'd9);

        // 5: reset during the 4th issue of a 3x3 pass.
        clear_counts();
        plan_pass(3, 3);
        d0 = done_cnt;
        start_pass(3, 3);
        repeat (3) tick();
        check("t5_4th_issue", 32'({issueValid, rowIdx, colIdx}), 32'({1'b1, 4'd1, 4'd0}));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_all_zero("t5_after_reset");
        exp_iss_q.delete();
        exp_res_q.delete();
        clear_counts();
        repeat (LAT + 3) tick();
        check("t5_no_stale_res", 32'(resv_cnt), 32'd0);
        check("t5_no_issue", 32'(issue_cnt), 32'd0);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        plan_pass(1, 1);
        start_pass(1, 1);
        wait_done("t5_1x1_done");
        check("t5_1x1_pops", 32'(pop_cnt), 32'd1);
        check("t5_sb_left", 32'(exp_res_q.size()), 32'd0);

        // 6: start while busy is ignored; the 2x2 pass completes unchanged.
        clear_counts();
        plan_pass(2, 2);
        d0 = done_cnt;
        start_pass(2, 2);
        tick();
        numRows = 4'd1;
        numCols = 4'd1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done("t6_done");
        repeat (3) tick();
        check("t6_issues", 32'(issue_cnt), 32'd4);
        check("t6_pops", 32'(pop_cnt), 32'd4);
        check("t6_done_once", 32'(done_cnt - d0), 32'd1);
        check("t6_sb_left", 32'(exp_res_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
